// File: rtl/hex_entry_if.sv
// Keypad-side command strobes, committed-word handshake and display taps for hex_entry.
// master is the keypad/consumer side, slave is the accumulator.
interface hex_entry_if #(
  parameter int DIGITS = 8
);
  localparam int W  = 4 * DIGITS;
  localparam int CW = $clog2(DIGITS + 1);

  logic          digit_valid;
  logic [3:0]    digit;
  logic          backspace;
  logic          clear;
  logic          enter;
  logic          word_ready;
  logic          word_valid;
  logic [W-1:0]  word;
  logic [W-1:0]  shown;
  logic [CW-1:0] count;
  logic          full;
  logic          err;

  modport master (
    output digit_valid, digit, backspace, clear, enter, word_ready,
    input  word_valid, word, shown, count, full, err
  );

  modport slave (
    input  digit_valid, digit, backspace, clear, enter, word_ready,
    output word_valid, word, shown, count, full, err
  );
endinterface

// File: rtl/hex_entry.sv
// Hex-digit entry accumulator: shifts keypad nibbles into an operand, supports
// backspace/clear, and offers the finished word over a valid/ready handshake.
module hex_entry #(
  parameter int DIGITS = 8
) (
  input logic       clk,
  input logic       rst,
  hex_entry_if.slave bus
);
  localparam int W  = 4 * DIGITS;
  localparam int CW = $clog2(DIGITS + 1);
  localparam logic [CW-1:0] MAX_COUNT = CW'(DIGITS);

  typedef enum logic [1:0] {EMPTY, ENTRY, HOLD} state_t;

  state_t        state, state_nxt;
  logic [W-1:0]  acc, acc_nxt;
  logic [CW-1:0] count, count_nxt;
  logic          err, err_nxt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= EMPTY;
      acc   <= '0;
      count <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      count <= count_nxt;
      err   <= err_nxt;
    end
  end

  // Only the highest-priority strobe acts; lower ones are dropped without err.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a variable unassigned and infer a latch.
    state_nxt = state;
    acc_nxt   = acc;
    count_nxt = count;
    err_nxt   = 1'b0;

    if (bus.clear) begin
      state_nxt = EMPTY;
      acc_nxt   = '0;
      count_nxt = '0;
    end else if (state == HOLD) begin
      // Operand is frozen while offered; any editing command is rejected.
      err_nxt = bus.enter | bus.backspace | bus.digit_valid;
      if (bus.word_ready) begin
        state_nxt = EMPTY;
        acc_nxt   = '0;
        count_nxt = '0;
      end
    end else if (bus.enter) begin
      if (state == EMPTY) err_nxt = 1'b1;
      else                state_nxt = HOLD;
    end else if (bus.backspace) begin
      if (state == EMPTY) begin
        err_nxt = 1'b1;
      end else begin
        acc_nxt   = {4'h0, acc[W-1:4]};
        count_nxt = count - CW'(1);
        if (count == CW'(1)) begin
          state_nxt = EMPTY;
          acc_nxt   = '0;
        end
      end
    end else if (bus.digit_valid) begin
      if (count == MAX_COUNT) begin
        err_nxt = 1'b1;
      end else begin
        acc_nxt   = {acc[W-5:0], bus.digit};
        count_nxt = count + CW'(1);
        state_nxt = ENTRY;
      end
    end
  end

  assign bus.word_valid = (state == HOLD);
  assign bus.word       = acc;
  assign bus.shown      = acc;
  assign bus.count      = count;
  assign bus.full       = (count == MAX_COUNT);
  assign bus.err        = err;
endmodule

// File: tb/tb_hex_entry.sv
// Directed bench for hex_entry: commit, overflow, backspace, hold/handshake,
// command priority and asynchronous reset.
module tb_hex_entry;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  hex_entry_if #(.DIGITS(8)) bus ();

  hex_entry #(.DIGITS(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs set before the call are sampled at the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.digit_valid = 1'b0;
    bus.digit       = 4'h0;
    bus.backspace   = 1'b0;
    bus.clear       = 1'b0;
    bus.enter       = 1'b0;
  endtask

  task automatic key(input logic [3:0] d);
    bus.digit_valid = 1'b1;
    bus.digit       = d;
    step();
    bus.digit_valid = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (bus.word_valid !== 1'b0) begin errors++; $display("FAIL reset_word_valid: got %b want 0", bus.word_valid); end
    checks++; if (bus.word !== 32'h0) begin errors++; $display("FAIL reset_word: got %h want 00000000", bus.word); end
    checks++; if (bus.shown !== 32'h0) begin errors++; $display("FAIL reset_shown: got %h want 00000000", bus.shown); end
    checks++; if (bus.count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", bus.count); end
    checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", bus.full); end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", bus.err); end
  endtask

  task automatic test_commit();
    bus.word_ready = 1'b1;
    for (int i = 1; i <= 4; i++) key(4'(i));
    checks++; if (bus.shown !== 32'h0000_1234) begin errors++; $display("FAIL commit_shown: got %h want 00001234", bus.shown); end
    checks++; if (bus.count !== 4'd4) begin errors++; $display("FAIL commit_count: got %0d want 4", bus.count); end
    bus.enter = 1'b1;
    step();
    bus.enter = 1'b0;
    checks++; if (bus.word_valid !== 1'b1) begin errors++; $display("FAIL commit_valid: got %b want 1", bus.word_valid); end
    checks++; if (bus.word !== 32'h0000_1234) begin errors++; $display("FAIL commit_word: got %h want 00001234", bus.word); end
    step();
    checks++; if (bus.word_valid !== 1'b0) begin errors++; $display("FAIL commit_valid_drop: got %b want 0", bus.word_valid); end
    checks++; if (bus.shown !== 32'h0) begin errors++; $display("FAIL commit_shown_after: got %h want 00000000", bus.shown); end
    checks++; if (bus.count !== 4'd0) begin errors++; $display("FAIL commit_count_after: got %0d want 0", bus.count); end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL commit_err: got %b want 0", bus.err); end
    bus.word_ready = 1'b0;
  endtask

  task automatic test_overflow();
    for (int i = 15; i >= 8; i--) key(4'(i));
    checks++; if (bus.shown !== 32'hFEDC_BA98) begin errors++; $display("FAIL ovf_shown8: got %h want fedcba98", bus.shown); end
    checks++; if (bus.full !== 1'b1) begin errors++; $display("FAIL ovf_full: got %b want 1", bus.full); end
    checks++; if (bus.count !== 4'd8) begin errors++; $display("FAIL ovf_count8: got %0d want 8", bus.count); end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL ovf_err_early: got %b want 0", bus.err); end
    key(4'h7);
    checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL ovf_err: got %b want 1", bus.err); end
    checks++; if (bus.shown !== 32'hFEDC_BA98) begin errors++; $display("FAIL ovf_shown9: got %h want fedcba98", bus.shown); end
    checks++; if (bus.count !== 4'd8) begin errors++; $display("FAIL ovf_count9: got %0d want 8", bus.count); end
    step();
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL ovf_err_width: got %b want 0", bus.err); end
    bus.clear = 1'b1;
    step();
    bus.clear = 1'b0;
    checks++; if (bus.shown !== 32'h0) begin errors++; $display("FAIL clear_shown: got %h want 00000000", bus.shown); end
    checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL clear_full: got %b want 0", bus.full); end
  endtask

  task automatic test_backspace();
    key(4'hA); key(4'hB); key(4'hC);
    bus.backspace = 1'b1;
    step(); step();
    bus.backspace = 1'b0;
    checks++; if (bus.shown !== 32'h0000_000A) begin errors++; $display("FAIL bs_shown: got %h want 0000000a", bus.shown); end
    checks++; if (bus.count !== 4'd1) begin errors++; $display("FAIL bs_count: got %0d want 1", bus.count); end
    bus.backspace = 1'b1;
    step();
    checks++; if (bus.shown !== 32'h0 || bus.count !== 4'd0) begin errors++; $display("FAIL bs_empty: got shown %h count %0d want 0/0", bus.shown, bus.count); end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL bs_empty_err: got %b want 0", bus.err); end
    step();
    bus.backspace = 1'b0;
    checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL bs_under_err: got %b want 1", bus.err); end
    checks++; if (bus.count !== 4'd0) begin errors++; $display("FAIL bs_under_count: got %0d want 0", bus.count); end
    bus.enter = 1'b1;
    step();
    bus.enter = 1'b0;
    checks++; if (bus.err !== 1'b1 || bus.word_valid !== 1'b0) begin errors++; $display("FAIL enter_empty: got err %b valid %b want 1/0", bus.err, bus.word_valid); end
  endtask

  task automatic test_hold();
    bus.word_ready = 1'b0;
    key(4'hA); key(4'hB); key(4'hC);
    bus.enter = 1'b1;
    step();
    bus.enter = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.digit_valid = 1'b1;
      bus.digit       = 4'(i + 3);
      step();
      checks++; if (bus.word_valid !== 1'b1 || bus.word !== 32'h0000_0ABC) begin errors++; $display("FAIL hold_word[%0d]: got valid %b word %h want 1/00000abc", i, bus.word_valid, bus.word); end
      checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL hold_err[%0d]: got %b want 1", i, bus.err); end
      checks++; if (bus.shown !== 32'h0000_0ABC || bus.count !== 4'd3) begin errors++; $display("FAIL hold_frozen[%0d]: got shown %h count %0d want 00000abc/3", i, bus.shown, bus.count); end
    end
    // Handshake edge with a digit still arriving: the digit is rejected.
    bus.word_ready = 1'b1;
    bus.digit      = 4'h5;
    step();
    bus.word_ready = 1'b0;
    checks++; if (bus.word_valid !== 1'b0 || bus.shown !== 32'h0) begin errors++; $display("FAIL hs_done: got valid %b shown %h want 0/00000000", bus.word_valid, bus.shown); end
    checks++; if (bus.err !== 1'b1 || bus.count !== 4'd0) begin errors++; $display("FAIL hs_digit_rej: got err %b count %0d want 1/0", bus.err, bus.count); end
    step();
    bus.digit_valid = 1'b0;
    checks++; if (bus.shown !== 32'h0000_0005 || bus.count !== 4'd1 || bus.err !== 1'b0) begin errors++; $display("FAIL b2b_digit: got shown %h count %0d err %b want 00000005/1/0", bus.shown, bus.count, bus.err); end
    bus.clear = 1'b1;
    step();
    bus.clear = 1'b0;
  endtask

  task automatic test_priority();
    key(4'h7);
    bus.clear = 1'b1; bus.enter = 1'b1;
    step();
    idle_inputs();
    checks++; if (bus.word_valid !== 1'b0 || bus.count !== 4'd0 || bus.err !== 1'b0) begin errors++; $display("FAIL clr_enter: got valid %b count %0d err %b want 0/0/0", bus.word_valid, bus.count, bus.err); end
    bus.clear = 1'b1; bus.backspace = 1'b1;
    step();
    idle_inputs();
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL clr_bs_empty_err: got %b want 0", bus.err); end
    key(4'h1); key(4'h2);
    bus.enter = 1'b1; bus.digit_valid = 1'b1; bus.digit = 4'h3;
    step();
    idle_inputs();
    checks++; if (bus.word_valid !== 1'b1 || bus.word !== 32'h0000_0012 || bus.err !== 1'b0) begin errors++; $display("FAIL enter_digit: got valid %b word %h err %b want 1/00000012/0", bus.word_valid, bus.word, bus.err); end
    bus.clear = 1'b1;
    step();
    bus.clear = 1'b0;
    checks++; if (bus.word_valid !== 1'b0 || bus.shown !== 32'h0) begin errors++; $display("FAIL clr_hold: got valid %b shown %h want 0/00000000", bus.word_valid, bus.shown); end
  endtask

  task automatic test_async_reset();
    key(4'h9);
    bus.enter = 1'b1;
    step();
    bus.enter = 1'b0;
    checks++; if (bus.word_valid !== 1'b1) begin errors++; $display("FAIL ar_hold: got %b want 1", bus.word_valid); end
    #2 rst = 1'b0;
    #1;
    checks++; if (bus.word_valid !== 1'b0 || bus.word !== 32'h0 || bus.shown !== 32'h0) begin errors++; $display("FAIL ar_outputs: got valid %b word %h shown %h want 0/0/0", bus.word_valid, bus.word, bus.shown); end
    checks++; if (bus.count !== 4'd0 || bus.full !== 1'b0 || bus.err !== 1'b0) begin errors++; $display("FAIL ar_count: got count %0d full %b err %b want 0/0/0", bus.count, bus.full, bus.err); end
    step();
    #2 rst = 1'b1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    idle_inputs();
    bus.word_ready = 1'b0;
    #12;
    test_reset();
    rst = 1'b1;
    test_commit();
    test_overflow();
    test_backspace();
    test_hold();
    test_priority();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
